// File: rtl/operand_fetch_stage_if.sv
// operand_fetch_stage_if: instruction intake and issue handshakes of the operand fetch stage
interface operand_fetch_stage_if #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32,
  parameter int INSTR_LEN   = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_LEN-1:0]   in_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_LEN-1:0]   out_instr;
  logic [RF_DATA_LEN-1:0] out_rs1_data;
  logic [RF_DATA_LEN-1:0] out_rs2_data;
  logic [RF_ADDR_LEN-1:0] out_rd_addr;
  logic                   out_rd_we;
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_rs1_data, out_rs2_data, out_rd_addr, out_rd_we
  );
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_rs1_data, out_rs2_data, out_rd_addr, out_rd_we
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode, operand fetch with writeback bypass, busy-scoreboard hazard stall
module operand_fetch_stage #(
  parameter int RF_ADDR_LEN = 5,
  parameter int RF_DATA_LEN = 32,
  parameter int INSTR_LEN   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  operand_fetch_stage_if.slave   io,
  output logic [RF_ADDR_LEN-1:0] rf_rs1_addr,
  output logic [RF_ADDR_LEN-1:0] rf_rs2_addr,
  input  logic [RF_DATA_LEN-1:0] rf_rs1_data,
  input  logic [RF_DATA_LEN-1:0] rf_rs2_data,
  input  logic                   wb_en,
  input  logic [RF_ADDR_LEN-1:0] wb_addr,
  input  logic [RF_DATA_LEN-1:0] wb_data
);
  localparam int NREG = 1 << RF_ADDR_LEN;
  logic                   id_valid;
  logic [INSTR_LEN-1:0]   id_instr;
  logic [NREG-1:0]        busy;
  logic [6:0]             op;
  logic [RF_ADDR_LEN-1:0] rs1, rs2, rd;
  logic                   uses_rs1, uses_rs2, rd_we;
  logic [RF_DATA_LEN-1:0] op1, op2;
  logic [NREG-1:0]        wb_mask, inflight_mask, set_mask, pend;
  logic                   hazard, issue, accept;
  assign op       = id_instr[6:0];
  assign rd       = id_instr[7 +: RF_ADDR_LEN];
  assign rs1      = id_instr[15 +: RF_ADDR_LEN];
  assign rs2      = id_instr[20 +: RF_ADDR_LEN];
  assign uses_rs1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  assign uses_rs2 = op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011;
  assign rd_we    = rd != '0 && !(op == 7'b0100011 || op == 7'b1100011 || op == 7'b0001111 || op == 7'b1110011);
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;
  assign op1 = rs1 == '0 ? '0 : (wb_en && wb_addr == rs1) ? wb_data : rf_rs1_data;
  assign op2 = rs2 == '0 ? '0 : (wb_en && wb_addr == rs2) ? wb_data : rf_rs2_data;
  // A register is pending while busy and not being written back now, or while its writer sits in OUT.
  assign wb_mask       = wb_en ? NREG'(1) << wb_addr : '0;
  assign inflight_mask = (io.out_valid && io.out_rd_we) ? NREG'(1) << io.out_rd_addr : '0;
  assign set_mask      = (io.out_valid && io.out_ready && io.out_rd_we) ? NREG'(1) << io.out_rd_addr : '0;
  assign pend          = (busy & ~wb_mask | inflight_mask) & ~NREG'(1);
  assign hazard = (uses_rs1 && pend[rs1]) || (uses_rs2 && pend[rs2]) || (rd_we && pend[rd]);
  assign issue  = id_valid && !hazard && (!io.out_valid || io.out_ready) && !flush;
  assign io.in_ready = !flush && (!id_valid || issue);
  assign accept = io.in_valid && io.in_ready;
  // ID/OUT slot advance and scoreboard; a set on the consumed rd overrides a same-cycle clear.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      id_valid        <= 1'b0;
      id_instr        <= '0;
      busy            <= '0;
      io.out_valid    <= 1'b0;
      io.out_instr    <= '0;
      io.out_rs1_data <= '0;
      io.out_rs2_data <= '0;
      io.out_rd_addr  <= '0;
      io.out_rd_we    <= 1'b0;
    end else begin
      busy         <= (busy & ~wb_mask | set_mask) & ~NREG'(1);
      id_valid     <= !flush && (accept || (id_valid && !issue));
      io.out_valid <= !flush && (issue || (io.out_valid && !io.out_ready));
      if (accept) id_instr <= io.in_instr;
      if (issue) begin
        io.out_instr    <= id_instr;
        io.out_rs1_data <= op1;
        io.out_rs2_data <= op2;
        io.out_rd_addr  <= rd;
        io.out_rd_we    <= rd_we;
      end
    end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage sitting directly upstream of register_file.
- Accepts instructions over a valid/ready handshake and drives the register file read addresses from the rs1/rs2 fields.
- Captures operands, bypassing the same-cycle writeback value, and issues to execute through an output register.
- A per-register busy scoreboard stalls RAW and WAW hazards against instructions still in flight.

Parameters:
- RF_ADDR_LEN, 5, register index width (2^RF_ADDR_LEN registers).
- RF_DATA_LEN, 32, register data width.
- INSTR_LEN, 32, instruction width; RISC-V field positions fixed (rd [11:7], rs1 [19:15], rs2 [24:20], opcode [6:0]).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  INSTR_LEN  instruction word.
- rf_rs1_addr  out  RF_ADDR_LEN  register file rs1 read address.
- rf_rs2_addr  out  RF_ADDR_LEN  register file rs2 read address.
- rf_rs1_data  in  RF_DATA_LEN  combinational read data for rs1.
- rf_rs2_data  in  RF_DATA_LEN  combinational read data for rs2.
- wb_en  in  1  writeback enable (same signal that drives register_file w_en).
- wb_addr  in  RF_ADDR_LEN  writeback destination.
- wb_data  in  RF_DATA_LEN  writeback data.
- out_valid  out  1  issued instruction valid.
- out_ready  in  1  execute stage accepts.
- out_instr  out  INSTR_LEN  issued instruction.
- out_rs1_data  out  RF_DATA_LEN  operand 1.
- out_rs2_data  out  RF_DATA_LEN  operand 2.
- out_rd_addr  out  RF_ADDR_LEN  destination index.
- out_rd_we  out  1  instruction writes rd.

Behaviour:
- Registers:
  - ID slot: id_valid, id_instr.
  - OUT slot: all out_* outputs.
  - busy[2^RF_ADDR_LEN-1:0].
- Reset: asynchronous. Clears id_valid, out_valid, out_instr, out_rs1_data, out_rs2_data, out_rd_addr, out_rd_we and all busy bits to 0.
- Decode (combinational, from id_instr):
  - uses_rs1: false for opcodes 0110111, 0010111, 1101111.
  - uses_rs2: true for opcodes 0110011, 0100011, 1100011.
  - rd_we: false for opcodes 0100011, 1100011, 0001111, 1110011, and false whenever rd==0.
- Read addresses: rf_rs1_addr and rf_rs2_addr are always the id_instr fields, independent of id_valid.
- Operand select, per source:
  - Source index 0 gives 0.
  - Else if wb_en and wb_addr equals the index, gives wb_data (bypass).
  - Else gives rf_*_data.
- Pending(r), for r != 0, is true when any of these holds:
  - busy[r] and not (wb_en and wb_addr==r);
  - out_valid and out_rd_we and out_rd_addr==r.
- Hazard: (uses_rs1 and pending(rs1)) or (uses_rs2 and pending(rs2)) or (rd_we and pending(rd)).
- out_free = !out_valid or out_ready.
- issue = id_valid and !hazard and out_free and !flush. On issue, the OUT slot loads the decoded values and out_valid becomes 1.
- If out_valid and out_ready and not issue: out_valid becomes 0.
- in_ready = !id_valid or issue (combinational).
  - in_valid and in_ready loads id_instr and sets id_valid.
  - Issue without a new accept clears id_valid.
  - Throughput is 1 instruction per cycle when there are no hazards.
- Latency: an instruction accepted at edge N appears with out_valid at edge N+1 at the earliest.
- Scoreboard update:
  - out_valid and out_ready and out_rd_we sets busy[out_rd_addr].
  - wb_en clears busy[wb_addr].
  - If set and clear hit the same index in the same cycle, set wins.
  - busy[0] is never set.
- Flush: clears id_valid and out_valid at the next edge. in_ready is 0 during the flush cycle. Busy bits are untouched, because they belong only to instructions already consumed by execute.
- Stall holds the OUT slot: while out_valid and !out_ready, all out_* outputs are stable.
- A writeback with no matching busy bit is harmless: the bit stays 0.

Test Plan:
- Reset mid-stream: id and out slots hold valid instructions, assert rst -> out_valid=0 and in_ready=1 immediately, all busy=0.
- Independent ops: issue ADD x3,x1,x2 with RF x1=5, x2=7, then ADD x4,x5,x6 on consecutive cycles -> out_valid is 1 on both following cycles, out_rs1_data=5 and out_rs2_data=7 for the first.
- RAW stall: ADD x8,... consumed, then ADD x9,x8,x0 -> in_ready=0 and no issue until wb_en with wb_addr=8, wb_data=24. Issues the same cycle with out_rs1_data=24 via bypass; busy[8] ends at 0.
- x0 handling: ADDI x0,x0,1 issues with out_rd_we=0; a following instruction reading x0 gets 0 even when wb_en=1, wb_addr=0, wb_data=3.
- Backpressure: out_ready=0 for 3 cycles -> out_* outputs stable, ID slot fills and then in_ready=0. Release -> both instructions drain in order.
- Flush: flush asserted with both slots valid -> out_valid=0 and id_valid=0 next cycle, busy bits unchanged. The next instruction is accepted normally.
